// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment BCD display driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } seg7_state_e;

    // Active-low patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [63:0] max_decimal(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD nibble to active-low seven-segment pattern.
module seg7_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Nibbles 10..15 cannot come out of the converter and show blank.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_driver.sv
// Binary to BCD (double-dabble, one bit per clock) driving NUM_DIGITS seven-segment digits.
// Define SEG7_BLANK_LEADING_EN to blank leading zero digits.
module seg7_bcd_driver
    import seg7_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 4
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [WIDTH-1:0]             value_in,
    output logic [NUM_DIGITS-1:0][6:0]   seg_out,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int              BCD_W     = 4 * NUM_DIGITS;
    localparam int              CNT_W     = $clog2(WIDTH + 1);
    localparam logic [63:0]     MAXV      = max_decimal(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    seg7_state_e                 state_q, state_d;
    logic [WIDTH-1:0]            shift_q, shift_d;
    logic [BCD_W-1:0]            bcd_q, bcd_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        ovf_pend_q, ovf_pend_d;
    logic [NUM_DIGITS-1:0][6:0]  seg_q, seg_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        overflow_q, overflow_d;

    logic [63:0]                 value_ext_s;
    logic                        clamp_s;
    logic [WIDTH-1:0]            capture_s;
    logic [BCD_W-1:0]            bcd_adj_s;
    logic [BCD_W-1:0]            bcd_step_s;
    logic [WIDTH-1:0]            shift_step_s;
    logic [NUM_DIGITS-1:0][6:0]  enc_s;
    logic [NUM_DIGITS-1:0][6:0]  disp_s;

    // Clamp comparison is done at 64 bits so it is simply never true when MAXV >= 2^WIDTH.
    always_comb begin
        value_ext_s = 64'(value_in);
        clamp_s     = (value_ext_s > MAXV);
        capture_s   = clamp_s ? MAXV[WIDTH-1:0] : value_in;
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj_s = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj_s[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                            : bcd_q[4*i +: 4];
        end
        bcd_step_s   = BCD_W'({bcd_adj_s, shift_q[WIDTH-1]});
        shift_step_s = shift_q << 1;
    end

    // Digits are encoded from the post-step value so seg_out is ready in the LOAD cycle.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seg7_encoder u_enc (
            .bcd_i (bcd_step_s[4*g +: 4]),
            .seg_o (enc_s[g])
        );
    end

`ifdef SEG7_BLANK_LEADING_EN
    // Blank every digit above the most significant non-zero one; digit 0 always shows.
    always_comb begin : blank_p
        logic leading;
        leading = 1'b1;
        disp_s  = enc_s;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            leading   = leading && (bcd_step_s[4*i +: 4] == 4'd0);
            disp_s[i] = leading ? SEG_BLANK : enc_s[i];
        end
    end
`else
    // All digits shown, leading zeros included.
    always_comb begin
        disp_s = enc_s;
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        seg_d      = seg_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    shift_d    = capture_s;
                    ovf_pend_d = clamp_s;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = CONVERT;
                end else begin
                    state_d    = IDLE;
                end
            end
            CONVERT: begin
                shift_d = shift_step_s;
                bcd_d   = bcd_step_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    seg_d      = disp_s;
                    overflow_d = ovf_pend_q;
                    done_d     = 1'b1;
                    state_d    = LOAD;
                end else begin
                    state_d    = CONVERT;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            seg_q      <= {NUM_DIGITS{SEG_BLANK}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            seg_q      <= seg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign seg_out  = seg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seg7_bcd_driver.sv
// Directed bench for seg7_bcd_driver: default 16-bit/4-digit instance plus an 8-bit/3-digit instance.
module tb_seg7_bcd_driver;

`ifdef SEG7_BLANK_LEADING_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              tick_a;
    logic [15:0]       value_a;
    logic [3:0][6:0]   seg_a;
    logic              busy_a, done_a, ovf_a;
    logic              tick_b;
    logic [7:0]        value_b;
    logic [2:0][6:0]   seg_b;
    logic              busy_b, done_b, ovf_b;

    int errors = 0;
    int checks = 0;

    seg7_bcd_driver #(.WIDTH(16), .NUM_DIGITS(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick_a),
        .value_in (value_a),
        .seg_out  (seg_a),
        .busy     (busy_a),
        .done     (done_a),
        .overflow (ovf_a)
    );

    seg7_bcd_driver #(.WIDTH(8), .NUM_DIGITS(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick_b),
        .value_in (value_b),
        .seg_out  (seg_b),
        .busy     (busy_b),
        .done     (done_b),
        .overflow (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Decimal reference display: digit i at bits [7i+6:7i].
    function automatic logic [55:0] exp_seg(input int v, input int nd);
        logic [55:0] r;
        int d [8];
        int p;
        int msd;
        r   = '1;
        p   = v;
        msd = 0;
        for (int i = 0; i < nd; i++) begin
            d[i] = p % 10;
            p    = p / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < nd; i++) begin
            r[7*i +: 7] = (BLANK_EN && i > msd) ? 7'b1111111 : pat(d[i]);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick dut_a with v, scramble value_in after capture, return cycles until done.
    task automatic run_a(input int v, output int lat);
        logic seen;
        tick_a  = 1'b1;
        value_a = 16'(v);
        lat     = 0;
        seen    = 1'b0;
        while (!seen && lat < 40) begin
            step();
            lat++;
            tick_a = 1'b0;
            if (lat == 1) value_a = 16'hFFFF;
            seen = done_a;
        end
    endtask

    task automatic run_b(input int v, output int lat);
        logic seen;
        tick_b  = 1'b1;
        value_b = 8'(v);
        lat     = 0;
        seen    = 1'b0;
        while (!seen && lat < 40) begin
            step();
            lat++;
            tick_b = 1'b0;
            seen = done_b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_a = 1'b0; tick_b = 1'b0; value_a = 16'd0; value_b = 8'd0;
        repeat (3) step();
        checks++; if (seg_a !== {4{7'b1111111}}) begin errors++; $display("FAIL reset_seg_a got=%h want=%h", seg_a, {4{7'b1111111}}); end
        checks++; if (seg_b !== {3{7'b1111111}}) begin errors++; $display("FAIL reset_seg_b got=%h want=%h", seg_b, {3{7'b1111111}}); end
        checks++; if ({busy_a, done_a, ovf_a} !== 3'b000) begin errors++; $display("FAIL reset_flags_a got=%b want=000", {busy_a, done_a, ovf_a}); end
        checks++; if ({busy_b, done_b, ovf_b} !== 3'b000) begin errors++; $display("FAIL reset_flags_b got=%b want=000", {busy_b, done_b, ovf_b}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        logic [55:0] e;
        run_a(1234, lat);
        e = exp_seg(1234, 4);
        checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got=%0d want=17", lat); end
        checks++; if (seg_a !== e[27:0]) begin errors++; $display("FAIL basic_seg got=%h want=%h", seg_a, e[27:0]); end
        checks++; if (seg_a !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin errors++; $display("FAIL basic_seg_literal got=%h", seg_a); end
        checks++; if ({busy_a, ovf_a} !== 2'b10) begin errors++; $display("FAIL basic_load_flags got=%b want=10", {busy_a, ovf_a}); end
        step();
        checks++; if ({busy_a, done_a} !== 2'b00) begin errors++; $display("FAIL basic_idle_flags got=%b want=00", {busy_a, done_a}); end
        checks++; if (seg_a !== e[27:0]) begin errors++; $display("FAIL basic_hold got=%h want=%h", seg_a, e[27:0]); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [55:0] e;
        run_a(12345, lat);
        checks++; if (seg_a !== {4{7'b0010000}}) begin errors++; $display("FAIL ovf_seg got=%h want=%h", seg_a, {4{7'b0010000}}); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", ovf_a); end
        step();
        run_a(42, lat);
        e = exp_seg(42, 4);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_latency got=%0d want=17", lat); end
        checks++; if (seg_a !== e[27:0]) begin errors++; $display("FAIL b2b_seg got=%h want=%h", seg_a, e[27:0]); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear got=%b want=0", ovf_a); end
    endtask

    task automatic test_ignore_busy_tick();
        int dones;
        logic [55:0] e;
        step();
        dones   = 0;
        tick_a  = 1'b1;
        value_a = 16'd500;
        for (int c = 1; c <= 40; c++) begin
            step();
            tick_a  = (c == 5);
            value_a = (c == 5) ? 16'd777 : 16'd500;
            if (done_a) dones++;
        end
        e = exp_seg(500, 4);
        checks++; if (dones !== 1) begin errors++; $display("FAIL busy_tick_dones got=%0d want=1", dones); end
        checks++; if (seg_a !== e[27:0]) begin errors++; $display("FAIL busy_tick_seg got=%h want=%h", seg_a, e[27:0]); end
    endtask

    task automatic test_reset_abort();
        int dones;
        tick_a  = 1'b1;
        value_a = 16'd8888;
        for (int c = 1; c <= 8; c++) begin
            step();
            tick_a = 1'b0;
        end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b want=1", busy_a); end
        rst = 1'b1;
        #1;
        checks++; if (seg_a !== {4{7'b1111111}}) begin errors++; $display("FAIL abort_seg got=%h want=%h", seg_a, {4{7'b1111111}}); end
        checks++; if ({busy_a, done_a, ovf_a} !== 3'b000) begin errors++; $display("FAIL abort_flags got=%b want=000", {busy_a, done_a, ovf_a}); end
        step();
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done_a) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        checks++; if (seg_a !== {4{7'b1111111}}) begin errors++; $display("FAIL abort_seg_held got=%h want=%h", seg_a, {4{7'b1111111}}); end
    endtask

    task automatic test_leading();
        int lat;
        logic [55:0] e;
        logic [27:0] lit;
        run_a(7, lat);
        e   = exp_seg(7, 4);
        lit = BLANK_EN ? {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}
                       : {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000};
        checks++; if (lat !== 17) begin errors++; $display("FAIL lead_latency got=%0d want=17", lat); end
        checks++; if (seg_a !== lit) begin errors++; $display("FAIL lead_seg7 got=%h want=%h", seg_a, lit); end
        checks++; if (seg_a !== e[27:0]) begin errors++; $display("FAIL lead_model got=%h want=%h", seg_a, e[27:0]); end
        step();
        run_a(0, lat);
        e = exp_seg(0, 4);
        checks++; if (seg_a !== e[27:0]) begin errors++; $display("FAIL lead_zero got=%h want=%h", seg_a, e[27:0]); end
    endtask

    task automatic test_small();
        int lat;
        logic [55:0] e;
        run_b(255, lat);
        e = exp_seg(255, 3);
        checks++; if (lat !== 9) begin errors++; $display("FAIL small_latency got=%0d want=9", lat); end
        checks++; if (seg_b !== e[20:0]) begin errors++; $display("FAIL small_seg got=%h want=%h", seg_b, e[20:0]); end
        checks++; if (seg_b !== {7'b0100100, 7'b0010010, 7'b0010010}) begin errors++; $display("FAIL small_seg_literal got=%h", seg_b); end
        checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL small_ovf got=%b want=0", ovf_b); end
        step();
        run_b(30, lat);
        e = exp_seg(30, 3);
        checks++; if (seg_b !== e[20:0]) begin errors++; $display("FAIL small_seg30 got=%h want=%h", seg_b, e[20:0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ignore_busy_tick();
        test_reset_abort();
        test_leading();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_bcd_driver.md
SEG7_BCD_DRIVER -- requirements
Module: seg7_bcd_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of the binary input value.
REQ-002 SHALL have parameter NUM_DIGITS, default 4: number of seven-segment digits driven (1..8).
REQ-003 SHALL have port clk, input, 1: single system clock, all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port tick, input, 1: one-cycle update strobe requesting capture of value_in.
REQ-006 SHALL have port value_in, input, WIDTH: unsigned binary value to display.
REQ-007 SHALL have port seg_out, output, NUM_DIGITS x 7: active-low segments, index 0 = least significant digit, bit order g..a (bit 6 = g).
REQ-008 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when seg_out is updated.
REQ-010 SHALL have port overflow, output, 1: high when the last displayed value was clamped.

Function
REQ-011 SHALL implement FSM states IDLE, CONVERT, LOAD.
REQ-012 IDLE: on tick=1, SHALL capture min(value_in, MAXV) into a shift register, where MAXV = 10^NUM_DIGITS - 1; capture overflow_pending = (value_in > MAXV); clear the BCD accumulator; go to CONVERT.
REQ-013 If MAXV >= 2^WIDTH, clamping SHALL never occur and overflow_pending SHALL be 0.
REQ-014 CONVERT: SHALL perform one shift-add-3 (double-dabble) step per clock, MSB first; in each step every BCD nibble >= 5 is incremented by 3 before the 1-bit left shift.
REQ-015 CONVERT SHALL last exactly WIDTH cycles, counted by an iteration counter of width clog2(WIDTH+1), then go to LOAD.
REQ-016 LOAD: SHALL drive each seg_out digit from its encoded BCD nibble, set overflow from overflow_pending, assert done for this one cycle, return to IDLE.
REQ-017 Latency: tick in cycle N SHALL yield updated seg_out and done=1 in cycle N+WIDTH+1.
REQ-018 busy SHALL be 1 in CONVERT and LOAD, 0 in IDLE.
REQ-019 tick while busy=1 SHALL be ignored (no queueing); tick in the cycle FSM enters IDLE from LOAD SHALL be accepted.
REQ-020 seg_out and overflow SHALL hold their values between LOAD cycles; value_in changes after capture SHALL have no effect.
REQ-021 BCD nibble values 10..15 (unreachable) SHALL encode to blank 7'b1111111.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, seg_out all 7'b1111111 (blank), busy=0, done=0, overflow=0, counter and registers zero.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow release.
REQ-024 First tick after rst release SHALL be accepted normally.

Configuration
REQ-025 Macro SEG7_BLANK_LEADING_EN SHALL enable leading-zero blanking.
REQ-026 With SEG7_BLANK_LEADING_EN defined: in LOAD, every digit above the most significant non-zero digit SHALL be blank; digit 0 SHALL always display (value 0 shows single "0").
REQ-027 Without SEG7_BLANK_LEADING_EN: all NUM_DIGITS digits SHALL display, including leading zeros.

Structure
REQ-028 Package seg7_pkg SHALL hold: FSM state enum, segment pattern constants for digits 0-9 and SEG_BLANK, and a constant function computing 10^n - 1.
REQ-029 Sub-module seg7_encoder SHALL be the combinational 4-bit BCD to 7-bit active-low encoder, instantiated NUM_DIGITS times.

Verification
REQ-030 rst, then tick with value_in=1234 -> done at tick+17 cycles, seg_out[3..0] = 1111001, 0100100, 0110000, 0011001, overflow=0.
REQ-031 tick with value_in=12345 -> displays 9999 (all 0010000), overflow=1; next tick with 42 -> overflow=0.
REQ-032 tick with 500, second tick 5 cycles later with 777 -> only 500 displayed, exactly one done pulse.
REQ-033 tick with 8888, rst asserted at cycle 8 of CONVERT -> seg_out blank, busy=0, no done after release.
REQ-034 tick with value_in=7 -> without SEG7_BLANK_LEADING_EN shows 0007; with it, digits 3..1 = 1111111, digit 0 = 1111000.
REQ-035 WIDTH=8, NUM_DIGITS=3, tick with 255 -> done at tick+9 cycles, displays 255, overflow=0.
